// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmit path among NREQ requesters
// Frames may lock the transmitter across bytes; a hold timeout frees a frame whose owner stalls.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int HOLD_TO = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   gnt,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_done,
  output logic              busy,
  output logic              to_err
);

  localparam int          IW       = $clog2(NREQ);
  localparam logic [15:0] HOLD_MAX = 16'(HOLD_TO);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, HOLD} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   owner, owner_nx;
  logic [IW-1:0]   ptr, ptr_nx;
  logic [15:0]     hold_cnt, hold_cnt_nx;
  logic            last_r, last_nx;
  logic [NREQ-1:0] ack_nx, gnt_nx;
  logic [7:0]      tx_data_nx;
  logic            tx_start_nx, to_err_nx, busy_nx;

  logic [IW-1:0]   winner;
  logic            found;
  logic            issue;
  logic [IW-1:0]   sel;

  // Search upward from ptr+1, wrapping at NREQ, so the last owner has lowest priority.
  always_comb begin : arbitrate
    logic [IW:0] sum;
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      if (!found && req[sum[IW-1:0]]) begin
        found  = 1'b1;
        winner = sum[IW-1:0];
      end
    end
  end

  always_comb begin
    state_nx    = state;
    owner_nx    = owner;
    ptr_nx      = ptr;
    hold_cnt_nx = hold_cnt;
    last_nx     = last_r;
    ack_nx      = '0;
    gnt_nx      = gnt;
    tx_data_nx  = tx_data;
    tx_start_nx = 1'b0;
    to_err_nx   = 1'b0;
    issue       = 1'b0;
    sel         = owner;

    case (state)
      IDLE: begin
        if (found) begin
          issue    = 1'b1;
          sel      = winner;
          owner_nx = winner;
          state_nx = SEND;
        end
      end
      SEND: begin
        state_nx = WAIT;
      end
      WAIT: begin
        if (tx_done) begin
          if (last_r) begin
            ptr_nx   = owner;
            gnt_nx   = '0;
            state_nx = IDLE;
          end else begin
            hold_cnt_nx = '0;
            state_nx    = HOLD;
          end
        end
      end
      HOLD: begin
        // to_err fires as the count reaches the limit; the release happens one cycle later.
        if (hold_cnt == HOLD_MAX) begin
          ptr_nx   = owner;
          gnt_nx   = '0;
          state_nx = IDLE;
        end else if (req[owner]) begin
          issue    = 1'b1;
          state_nx = SEND;
        end else begin
          hold_cnt_nx = hold_cnt + 16'd1;
          if (hold_cnt_nx == HOLD_MAX) to_err_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Outputs are registered, so the byte is launched on the edge that enters SEND.
    if (issue) begin
      tx_start_nx = 1'b1;
      tx_data_nx  = req_data[{sel, 3'b000} +: 8];
      ack_nx[sel] = 1'b1;
      last_nx     = req_last[sel];
      gnt_nx      = '0;
      gnt_nx[sel] = 1'b1;
    end

    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= '0;
      ptr      <= IW'(NREQ-1);
      hold_cnt <= '0;
      last_r   <= 1'b0;
      ack      <= '0;
      gnt      <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      busy     <= 1'b0;
      to_err   <= 1'b0;
    end else begin
      state    <= state_nx;
      owner    <= owner_nx;
      ptr      <= ptr_nx;
      hold_cnt <= hold_cnt_nx;
      last_r   <= last_nx;
      ack      <= ack_nx;
      gnt      <= gnt_nx;
      tx_data  <= tx_data_nx;
      tx_start <= tx_start_nx;
      busy     <= busy_nx;
      to_err   <= to_err_nx;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a queue-based round-robin model
// Requesters replay byte queues; a transmitter model answers each tx_start with a delayed tx_done.
module tb_uart_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int HOLD_TO = 16;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req, req_last, ack, gnt;
  logic [31:0] req_data;
  logic [7:0]  tx_data;
  logic        tx_start, tx_done, busy, to_err;
  logic        tx_done_m, tx_done_s;

  assign tx_done = tx_done_m | tx_done_s;

  logic [8:0]  rq [NREQ][$];
  logic [8:0]  mq [NREQ][$];
  logic [15:0] exp_q [$];

  int checks      = 0;
  int failures    = 0;
  int model_ptr   = NREQ - 1;
  int fixed_delay = 0;
  int n_start     = 0;
  int n_done      = 0;
  bit allow_to_err = 1'b0;

  uart_tx_arbiter #(.NREQ(NREQ), .HOLD_TO(HOLD_TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .req_last (req_last),
    .ack      (ack),
    .gnt      (gnt),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_done  (tx_done),
    .busy     (busy),
    .to_err   (to_err)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, want);
    end
  endtask

  task automatic add(input int i, input logic [7:0] d, input logic l);
    rq[i].push_back({l, d});
    mq[i].push_back({l, d});
  endtask

  // Whole frames are granted round-robin starting after the previous owner.
  task automatic model_run();
    int p, s;
    logic [8:0] e;
    bit found;
    found = 1'b1;
    while (found) begin
      found = 1'b0;
      s = 0;
      for (int k = 1; k <= NREQ; k++) begin
        p = (model_ptr + k) % NREQ;
        if (!found && mq[p].size() > 0) begin
          found = 1'b1;
          s = p;
        end
      end
      if (found) begin
        e = mq[s].pop_front();
        exp_q.push_back({8'(s), e[7:0]});
        while (!e[8] && mq[s].size() > 0) begin
          e = mq[s].pop_front();
          exp_q.push_back({8'(s), e[7:0]});
        end
        model_ptr = s;
      end
    end
  endtask

  function automatic bit pending();
    bit p;
    p = (exp_q.size() != 0);
    for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((pending() || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_idle", 32'(pending() || busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_start(input int budget);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      if (tx_start) ok = 1'b1;
    end
    check("tx_start_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_done_edge(input int budget);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(posedge clk);
      if (tx_done) ok = 1'b1;
    end
    check("tx_done_seen", 32'(ok), 32'd1);
  endtask

  // Requesters: present the head of each queue, pop it on ack.
  initial begin : driver
    logic [8:0] h;
    req = '0; req_last = '0; req_data = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++)
        if (ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      for (int i = 0; i < NREQ; i++) begin
        if (rq[i].size() > 0) begin
          h = rq[i][0];
          req[i] = 1'b1;
          req_last[i] = h[8];
          req_data[8*i +: 8] = h[7:0];
        end else begin
          req[i] = 1'b0;
          req_last[i] = 1'b0;
        end
      end
    end
  end

  initial begin : xmit
    int d;
    bit aborted;
    tx_done_m = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && rst_n) begin
        d = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 12));
        aborted = 1'b0;
        for (int c = 0; c < d && !aborted; c++) begin
          @(negedge clk);
          if (!rst_n) aborted = 1'b1;
        end
        if (!aborted) begin
          tx_done_m = 1'b1;
          @(negedge clk);
          tx_done_m = 1'b0;
        end
        n_done++;
      end
    end
  end

  initial begin : monitor
    int ow;
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (tx_start || ack != 0) check("start_ack_coincident", 32'(tx_start), 32'(ack != 0));
      if (to_err && !allow_to_err) check("unexpected_to_err", 32'(to_err), 32'd0);
      if (tx_start) begin
        check("one_start_per_done", n_start, n_done);
        n_start++;
        check("gnt_eq_ack", 32'(gnt), 32'(ack));
        ow = 0;
        for (int i = 0; i < NREQ; i++) if (ack[i]) ow = i;
        if (exp_q.size() == 0) begin
          check("unexpected_byte", exp_q.size(), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("byte_owner_data", {8'(ow), tx_data}, e);
        end
      end
    end
  end

  initial begin : main
    int first_to, cnt_to, starts, seen;
    rst_n = 1'b0;
    tx_done_s = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ack", 32'(ack), 0);
    check("reset_gnt", 32'(gnt), 0);
    check("reset_tx_data", 32'(tx_data), 0);
    check("reset_tx_start", 32'(tx_start), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_to_err", 32'(to_err), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_req_busy", 32'(busy), 0);

    // Single byte with a slow transmitter
    fixed_delay = 100;
    add(1, 8'h55, 1'b1);
    model_run();
    seen = 0;
    while (!req[1] && seen < 5) begin
      @(negedge clk);
      seen++;
    end
    check("latency_not_early", 32'(tx_start), 0);
    @(negedge clk);
    check("single_tx_start", 32'(tx_start), 1);
    check("single_gnt", 32'(gnt), 32'h2);
    check("single_ack", 32'(ack), 32'h2);
    check("single_tx_data", 32'(tx_data), 32'h55);
    wait_done_edge(200);
    @(negedge clk);
    check("single_gnt_clear", 32'(gnt), 0);
    check("single_busy_clear", 32'(busy), 0);
    fixed_delay = 0;
    wait_idle(300);

    // Spurious tx_done in IDLE
    tx_done_s = 1'b1;
    @(negedge clk);
    tx_done_s = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      seen += int'(tx_start | busy);
    end
    check("spur_idle_quiet", seen, 0);

    // Fairness
    add(0, 8'h10, 1'b1); add(0, 8'h11, 1'b1);
    add(2, 8'h20, 1'b1); add(2, 8'h21, 1'b1);
    model_run();
    wait_idle(500);
    add(0, 8'h12, 1'b1); add(0, 8'h13, 1'b1);
    add(2, 8'h22, 1'b1); add(2, 8'h23, 1'b1);
    add(3, 8'h30, 1'b1); add(3, 8'h31, 1'b1);
    model_run();
    wait_idle(800);

    // Locked frame from requester 1 while requester 0 waits
    add(0, 8'h01, 1'b1);
    model_run();
    wait_idle(300);
    add(1, 8'h41, 1'b0); add(1, 8'h42, 1'b0); add(1, 8'h43, 1'b1);
    add(0, 8'h02, 1'b1);
    model_run();
    wait_idle(500);

    // Hold timeout: requester 2 abandons its frame after one byte
    fixed_delay = 5;
    allow_to_err = 1'b1;
    rq[2].push_back({1'b0, 8'hA5});
    exp_q.push_back({8'd2, 8'hA5});
    wait_done_edge(100);
    first_to = 0; cnt_to = 0; starts = 0;
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      if (n == 3) tx_done_s = 1'b1;
      if (n == 4) tx_done_s = 1'b0;
      if (n == 5) begin
        model_ptr = 2;
        add(3, 8'hB3, 1'b1);
        add(1, 8'hB1, 1'b1);
        model_run();
      end
      if (to_err) begin
        cnt_to++;
        if (first_to == 0) first_to = n;
      end
      starts += int'(tx_start);
      if (n == 17) check("hold_gnt_at_to", 32'(gnt), 32'h4);
      if (n == 18) begin
        check("timeout_gnt_clear", 32'(gnt), 0);
        check("timeout_busy_clear", 32'(busy), 0);
      end
    end
    check("to_err_cycle", first_to, HOLD_TO + 1);
    check("to_err_width", cnt_to, 1);
    check("hold_no_start", starts, 0);
    fixed_delay = 0;
    wait_idle(500);
    allow_to_err = 1'b0;

    // Randomized rounds
    for (int r = 0; r < 15; r++) begin
      for (int i = 0; i < NREQ; i++) begin
        int nf, len;
        nf = int'($urandom_range(0, 2));
        for (int f = 0; f < nf; f++) begin
          len = int'($urandom_range(1, 3));
          for (int b = 0; b < len; b++) add(i, 8'($urandom), b == len - 1);
        end
      end
      model_run();
      wait_idle(3000);
    end

    // Reset during WAIT
    fixed_delay = 100;
    add(0, 8'hC3, 1'b1);
    model_run();
    wait_start(20);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_mid_wait_outputs", {ack, gnt, tx_data, tx_start, busy, to_err}, 0);
    repeat (2) @(negedge clk);
    check("reset_hold_outputs", {ack, gnt, tx_data, tx_start, busy, to_err}, 0);
    rst_n = 1'b1;
    fixed_delay = 0;
    model_ptr = NREQ - 1;
    add(3, 8'hD3, 1'b1);
    add(0, 8'hD0, 1'b1);
    model_run();
    wait_start(20);
    check("post_reset_first_gnt", 32'(gnt), 32'h1);
    wait_idle(500);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
